// File: rtl/trig_pkg.sv
// Shared definitions for the trigger capture controller: state encoding and parameter bounds.
package trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_ADDR_W  = 10;
  localparam int PRE_CNT_MIN = 1;

  // At least one slot must remain for the trigger sample itself.
  function automatic int pre_cnt_max(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/trig_align_dly.sv
// WIDTH x DEPTH shift register; delays din by DEPTH cycles (DEPTH=0 is a wire). No backpressure.
module trig_align_dly #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/trig_capture_ctrl.sv
// Pre/post-trigger capture into a circular RAM; all control outputs registered, WrData = Din delayed ALIGN_DLY.
// Optional macro TRIG_FORCE_EN adds the ForceTrig input and Forced flag. No backpressure: one write per cycle.
module trig_capture_ctrl
  import trig_pkg::*;
#(
  parameter int CH_NUM    = 8,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PRE_CNT   = 256,
  parameter int ALIGN_DLY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Arm,
  input  logic              Abort,
  input  logic [CH_NUM-1:0] ResTri,
  input  logic [CH_NUM-1:0] Din,
`ifdef TRIG_FORCE_EN
  input  logic              ForceTrig,
  output logic              Forced,
`endif
  output logic [ADDR_W-1:0] WrAddr,
  output logic              WrEn,
  output logic [CH_NUM-1:0] WrData,
  output logic              TrigEN,
  output logic              Triggered,
  output logic [ADDR_W-1:0] TrigAddr,
  output logic              Done,
  output logic              Busy
);

  localparam int DEPTH = 1 << ADDR_W;
  // Out-of-range PRE_CNT is clamped so the window still fits the RAM exactly once.
  localparam int PRE_N = (PRE_CNT < PRE_CNT_MIN)         ? PRE_CNT_MIN :
                         (PRE_CNT > pre_cnt_max(ADDR_W)) ? pre_cnt_max(ADDR_W) : PRE_CNT;
  localparam int POST_N = DEPTH - PRE_N - 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_N - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);

  state_t            st;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic              rearm;
  logic              hit;
  logic              trig_fire;
  logic              go_idle;

  assign hit = &ResTri;

`ifdef TRIG_FORCE_EN
  logic force_pend;
  assign trig_fire = hit | ForceTrig | force_pend;
`else
  assign trig_fire = hit;
`endif

  // Abort from any active state, or Arm in DONE (which re-arms after one IDLE cycle).
  assign go_idle = (Abort && (st != ST_IDLE)) || ((st == ST_DONE) && Arm);

  trig_align_dly #(
    .WIDTH (CH_NUM),
    .DEPTH (ALIGN_DLY)
  ) u_align (
    .clk  (CLK),
    .rst  (RST),
    .din  (Din),
    .dout (WrData)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      st        <= ST_IDLE;
      WrAddr    <= '0;
      WrEn      <= 1'b0;
      TrigEN    <= 1'b0;
      Triggered <= 1'b0;
      TrigAddr  <= '0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rearm     <= 1'b0;
`ifdef TRIG_FORCE_EN
      Forced     <= 1'b0;
      force_pend <= 1'b0;
`endif
    end else if (go_idle) begin
      st        <= ST_IDLE;
      WrEn      <= 1'b0;
      TrigEN    <= 1'b0;
      Busy      <= 1'b0;
      Triggered <= 1'b0;
      Done      <= 1'b0;
      WrAddr    <= '0;
      pre_cnt   <= '0;
      rearm     <= !Abort;
`ifdef TRIG_FORCE_EN
      Forced     <= 1'b0;
      force_pend <= 1'b0;
`endif
    end else begin
      case (st)
        ST_IDLE: begin
          WrAddr    <= '0;
          pre_cnt   <= '0;
          Triggered <= 1'b0;
          Done      <= 1'b0;
          if (Arm || rearm) begin
            st    <= ST_PRE;
            WrEn  <= 1'b1;
            Busy  <= 1'b1;
            rearm <= 1'b0;
          end
        end
        ST_PRE: begin
          WrAddr  <= WrAddr + 1'b1;
          pre_cnt <= pre_cnt + 1'b1;
          if (pre_cnt == PRE_LAST) begin
            st     <= ST_ARMED;
            TrigEN <= 1'b1;
          end
`ifdef TRIG_FORCE_EN
          force_pend <= force_pend | ForceTrig;
`endif
        end
        ST_ARMED: begin
          WrAddr <= WrAddr + 1'b1;
          if (trig_fire) begin
            TrigAddr  <= WrAddr;
            Triggered <= 1'b1;
            TrigEN    <= 1'b0;
            post_cnt  <= '0;
`ifdef TRIG_FORCE_EN
            Forced     <= !hit;
            force_pend <= 1'b0;
`endif
            if (POST_N == 0) begin
              st   <= ST_DONE;
              WrEn <= 1'b0;
              Busy <= 1'b0;
              Done <= 1'b1;
            end else begin
              st <= ST_POST;
            end
          end
        end
        ST_POST: begin
          WrAddr   <= WrAddr + 1'b1;
          post_cnt <= post_cnt + 1'b1;
          if (post_cnt == POST_LAST) begin
            st   <= ST_DONE;
            WrEn <= 1'b0;
            Busy <= 1'b0;
            Done <= 1'b1;
          end
        end
        ST_DONE: begin
          WrEn <= 1'b0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Scoreboarded bench for trig_capture_ctrl with a 16-deep RAM and 4 pre-trigger samples.
module tb_trig_capture_ctrl;

  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Arm = 1'b0;
  logic          Abort = 1'b0;
  logic [7:0]    ResTri = 8'hFF;
  logic [7:0]    Din = 8'h00;
`ifdef TRIG_FORCE_EN
  logic          ForceTrig = 1'b0;
  logic          Forced;
`endif
  logic [AW-1:0] WrAddr;
  logic          WrEn;
  logic [7:0]    WrData;
  logic          TrigEN;
  logic          Triggered;
  logic [AW-1:0] TrigAddr;
  logic          Done;
  logic          Busy;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [AW-1:0] sb [$];
  logic [7:0]    din_hist [0:8191];
  logic [7:0]    ram [0:15];

  trig_capture_ctrl #(
    .CH_NUM    (8),
    .ADDR_W    (AW),
    .PRE_CNT   (4),
    .ALIGN_DLY (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Arm       (Arm),
    .Abort     (Abort),
    .ResTri    (ResTri),
    .Din       (Din),
`ifdef TRIG_FORCE_EN
    .ForceTrig (ForceTrig),
    .Forced    (Forced),
`endif
    .WrAddr    (WrAddr),
    .WrEn      (WrEn),
    .WrData    (WrData),
    .TrigEN    (TrigEN),
    .Triggered (Triggered),
    .TrigAddr  (TrigAddr),
    .Done      (Done),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  // Every RAM write is checked against the expected address stream and the Din driven two cycles earlier.
  always @(negedge CLK) begin
    if (WrEn === 1'b1) begin
      logic [AW-1:0] exp_addr;
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write: addr=%0d with no write expected (cycle %0d)", WrAddr, cyc);
      end else begin
        exp_addr = sb.pop_front();
        if (WrAddr !== exp_addr) begin
          errs++;
          $display("FAIL wr_addr: got %0d expected %0d (cycle %0d)", WrAddr, exp_addr, cyc);
        end
      end
      if (cyc >= 2) begin
        vecs++;
        if (WrData !== din_hist[cyc-2]) begin
          errs++;
          $display("FAIL wr_data: got %h expected %h (cycle %0d)", WrData, din_hist[cyc-2], cyc);
        end
      end
      ram[WrAddr] = WrData;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    Arm   = 1'b0;
    Abort = 1'b0;
`ifdef TRIG_FORCE_EN
    ForceTrig = 1'b0;
`endif
    Din = 8'($urandom);
    din_hist[cyc] = Din;
  endtask

  task automatic set_din(input logic [7:0] v);
    Din = v;
    din_hist[cyc] = v;
  endtask

  task automatic push_range(input int n);
    for (int k = 0; k < n; k++) sb.push_back(AW'(k));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (Done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    vecs++;
    if ({WrAddr, WrEn, WrData, TrigEN, Triggered, TrigAddr, Done, Busy} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %h expected all zero",
               {WrAddr, WrEn, WrData, TrigEN, Triggered, TrigAddr, Done, Busy});
    end
    RST = 1'b0;
    step();
    step();
    vecs++;
    if ({WrEn, Busy, Done, Triggered} !== 4'b0000) begin
      errs++;
      $display("FAIL idle_hold: got %b expected 0000", {WrEn, Busy, Done, Triggered});
    end
  endtask

  task automatic test_basic();
    int a;
    ResTri = 8'hFF;
    while (cyc < 5) step();
    Arm = 1'b1;
    a = cyc;
    push_range(16);
    step();
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if ({TrigEN, Busy} !== 2'b01) begin
        errs++;
        $display("FAIL pre_trigen_busy[%0d]: got %b expected 01", i, {TrigEN, Busy});
      end
      step();
    end
    vecs++;
    if ({TrigEN, Triggered} !== 2'b10) begin
      errs++;
      $display("FAIL first_armed: TrigEN,Triggered got %b expected 10", {TrigEN, Triggered});
    end
    step();
    vecs++;
    if ({Triggered, TrigEN, TrigAddr} !== {2'b10, 4'd4}) begin
      errs++;
      $display("FAIL basic_trigger: Triggered=%b TrigEN=%b TrigAddr=%0d expected 1,0,4",
               Triggered, TrigEN, TrigAddr);
    end
    wait_done(30);
    vecs++;
    if (Done !== 1'b1 || cyc - a != 17) begin
      errs++;
      $display("FAIL basic_done_time: Done=%b after %0d cycles expected 1 after 17", Done, cyc - a);
    end
    step();
    vecs++;
    if ({WrEn, Busy, Done} !== 3'b001 || sb.size() != 0) begin
      errs++;
      $display("FAIL basic_done_state: WrEn,Busy,Done=%b pending=%0d expected 001 and 0",
               {WrEn, Busy, Done}, sb.size());
    end
  endtask

  task automatic test_trig_wrap();
    int  a;
    bit  early = 1'b0;
    ResTri = 8'hFE;
    Abort = 1'b1;
    step();
    Arm = 1'b1;
    a = cyc;
    push_range(4 + 101 + 11);
    while (cyc < a + 105) begin
      step();
      if (Triggered !== 1'b0) early = 1'b1;
    end
    ResTri = 8'hFF;
    vecs++;
    if (early) begin
      errs++;
      $display("FAIL wrap_no_early: Triggered rose while ResTri=FE, expected it to stay 0");
    end
    step();
    vecs++;
    if ({Triggered, TrigAddr} !== {1'b1, 4'd8}) begin
      errs++;
      $display("FAIL wrap_trigger: Triggered=%b TrigAddr=%0d expected 1 and 8", Triggered, TrigAddr);
    end
    wait_done(30);
    vecs++;
    if (Done !== 1'b1 || sb.size() != 0) begin
      errs++;
      $display("FAIL wrap_done: Done=%b pending=%0d expected 1 and 0", Done, sb.size());
    end
  endtask

  task automatic test_align();
    ResTri = 8'hFE;
    Abort = 1'b1;
    step();
    Arm = 1'b1;
    push_range(4 + 4 + 11);
    for (int i = 0; i < 6; i++) step();
    set_din(8'hA5);
    step();
    step();
    ResTri = 8'hFF;
    step();
    ResTri = 8'hFE;
    vecs++;
    if ({Triggered, TrigAddr} !== {1'b1, 4'd7} || ram[7] !== 8'hA5) begin
      errs++;
      $display("FAIL align_word: Triggered=%b TrigAddr=%0d ram=%h expected 1, 7, a5",
               Triggered, TrigAddr, ram[7]);
    end
    wait_done(30);
    vecs++;
    if (Done !== 1'b1 || sb.size() != 0) begin
      errs++;
      $display("FAIL align_done: Done=%b pending=%0d expected 1 and 0", Done, sb.size());
    end
  endtask

  task automatic test_rst_post();
    ResTri = 8'hFF;
    Abort = 1'b1;
    step();
    Arm = 1'b1;
    push_range(8);
    for (int i = 0; i < 8; i++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    vecs++;
    if ({WrAddr, WrEn, WrData, TrigEN, Triggered, TrigAddr, Done, Busy} !== '0 || sb.size() != 0) begin
      errs++;
      $display("FAIL rst_in_post: outputs=%h pending=%0d expected 0 and 0",
               {WrAddr, WrEn, WrData, TrigEN, Triggered, TrigAddr, Done, Busy}, sb.size());
    end
    step();
    step();
    Arm = 1'b1;
    push_range(16);
    step();
    vecs++;
    if ({WrEn, WrAddr} !== {1'b1, 4'd0}) begin
      errs++;
      $display("FAIL rst_restart: WrEn=%b WrAddr=%0d expected 1 and 0", WrEn, WrAddr);
    end
    wait_done(30);
    vecs++;
    if (Done !== 1'b1 || sb.size() != 0) begin
      errs++;
      $display("FAIL rst_restart_done: Done=%b pending=%0d expected 1 and 0", Done, sb.size());
    end
  endtask

  task automatic test_abort_arm();
    int a;
    ResTri = 8'hFE;
    Abort = 1'b1;
    step();
    Arm = 1'b1;
    push_range(6);
    for (int i = 0; i < 6; i++) step();
    Abort = 1'b1;
    Arm = 1'b1;
    step();
    vecs++;
    if ({WrEn, Busy, TrigEN, Triggered} !== 4'b0000) begin
      errs++;
      $display("FAIL abort_wins: WrEn,Busy,TrigEN,Triggered=%b expected 0000",
               {WrEn, Busy, TrigEN, Triggered});
    end
    for (int i = 0; i < 3; i++) step();
    vecs++;
    if ({WrEn, Busy} !== 2'b00 || sb.size() != 0) begin
      errs++;
      $display("FAIL abort_stays_idle: WrEn,Busy=%b pending=%0d expected 00 and 0", {WrEn, Busy}, sb.size());
    end
    ResTri = 8'hFF;
    Arm = 1'b1;
    a = cyc;
    push_range(16);
    for (int i = 0; i < 7; i++) step();
    Arm = 1'b1;
    step();
    wait_done(30);
    vecs++;
    if (Done !== 1'b1 || cyc - a != 17 || sb.size() != 0) begin
      errs++;
      $display("FAIL arm_in_post: Done=%b after %0d cycles pending=%0d expected 1, 17, 0",
               Done, cyc - a, sb.size());
    end
  endtask

  task automatic test_rearm();
    int d;
    ResTri = 8'hFF;
    Arm = 1'b1;
    d = cyc;
    push_range(16);
    step();
    vecs++;
    if ({Done, Triggered, WrEn, Busy, WrAddr} !== '0) begin
      errs++;
      $display("FAIL rearm_idle: Done,Triggered,WrEn,Busy=%b WrAddr=%0d expected 0000 and 0",
               {Done, Triggered, WrEn, Busy}, WrAddr);
    end
    step();
    vecs++;
    if ({WrEn, Busy, WrAddr} !== {2'b11, 4'd0}) begin
      errs++;
      $display("FAIL rearm_pre: WrEn,Busy=%b WrAddr=%0d expected 11 and 0", {WrEn, Busy}, WrAddr);
    end
    wait_done(30);
    vecs++;
    if (Done !== 1'b1 || cyc - d != 18 || sb.size() != 0) begin
      errs++;
      $display("FAIL rearm_done: Done=%b after %0d cycles pending=%0d expected 1, 18, 0",
               Done, cyc - d, sb.size());
    end
  endtask

`ifdef TRIG_FORCE_EN
  task automatic test_force();
    ResTri = 8'h00;
    Abort = 1'b1;
    step();
    Arm = 1'b1;
    push_range(4 + 2 + 11);
    for (int i = 0; i < 6; i++) step();
    ForceTrig = 1'b1;
    step();
    vecs++;
    if ({Triggered, Forced, TrigAddr} !== {2'b11, 4'd5}) begin
      errs++;
      $display("FAIL force_trigger: Triggered=%b Forced=%b TrigAddr=%0d expected 1,1,5",
               Triggered, Forced, TrigAddr);
    end
    wait_done(30);
    vecs++;
    if (Done !== 1'b1 || sb.size() != 0) begin
      errs++;
      $display("FAIL force_done: Done=%b pending=%0d expected 1 and 0", Done, sb.size());
    end
  endtask
`endif

  initial begin
    din_hist[0] = Din;
    test_reset();
    test_basic();
    test_trig_wrap();
    test_align();
    test_rst_post();
    test_abort_arm();
    test_rearm();
`ifdef TRIG_FORCE_EN
    test_force();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/trig_capture_ctrl.md
Name: trig_capture_ctrl

Overview:
- Sits directly downstream of the per-channel trig instances and consumes their ResTri outputs.
- Combines all channel results into one trigger event.
- Runs the pre-trigger/post-trigger capture sequence into a circular sample RAM: generates write address, write enable and write data.
- Reports trigger address and completion to the host-side readout logic.

Parameters:
- CH_NUM, 8, number of channels: ResTri inputs and Din bits.
- ADDR_W, 10, sample RAM address width; depth = 2^ADDR_W.
- PRE_CNT, 256, samples guaranteed stored before the trigger sample; must be < 2^ADDR_W.
- ALIGN_DLY, 2, Din delay in cycles, matching the trig XinReg sampling latency.

Ports:
- CLK  in  1  sample clock, shared with the trig instances
- RST  in  1  synchronous, active-high reset
- Arm  in  1  one-cycle pulse; starts a capture
- Abort  in  1  one-cycle pulse; returns the block to IDLE
- ResTri  in  CH_NUM  per-channel trigger results
- Din  in  CH_NUM  raw channel samples, same bits that feed the trig Xin inputs
- WrAddr  out  ADDR_W  RAM write address
- WrEn  out  1  RAM write strobe
- WrData  out  CH_NUM  aligned sample
- TrigEN  out  1  drives the EN input of every trig instance
- Triggered  out  1  sticky trigger flag
- TrigAddr  out  ADDR_W  RAM address holding the trigger sample
- Done  out  1  capture complete, sticky
- Busy  out  1  state is not IDLE and not DONE

Behaviour:
- Reset values: all outputs 0; state IDLE.
  - RST has priority over every other input.
  - RST mid-capture discards the capture. RAM content is not cleared.
- Sample alignment: WrData = Din delayed by ALIGN_DLY registers, so the sample written in the cycle ResTri is evaluated is the sample that caused it.
- Trigger condition: Hit = &ResTri. Disabled channels report 1, so they do not block the trigger.
- States:
  - IDLE:
    - Arm → PRE.
    - Clear Triggered, Done, WrAddr and PreCnt.
  - PRE:
    - WrEn=1, WrAddr+1 per cycle, PreCnt+1 per cycle.
    - TrigEN=0, so Hit is ignored.
    - When PreCnt == PRE_CNT-1 on a write → ARMED.
  - ARMED:
    - WrEn=1, WrAddr increments with wrap at 2^ADDR_W.
    - TrigEN=1.
    - Hit=1 → TrigAddr := current WrAddr, Triggered := 1, PostCnt := 0 → POST.
  - POST:
    - WrEn=1, WrAddr increments.
    - TrigEN=0.
    - Stop after exactly 2^ADDR_W - PRE_CNT - 1 further writes, then → DONE.
    - Total window: PRE_CNT pre samples, the trigger sample, and the remaining post samples fill the RAM exactly once.
  - DONE:
    - WrEn=0, Done=1.
    - Arm → IDLE for one cycle, then → PRE (re-arm).
- TrigEN timing: TrigEN is registered and asserted in the first ARMED cycle. The trig ResTri path is combinational on EN, so Hit is qualified with the state, not with TrigEN.
- Abort: in any state other than IDLE, Abort → IDLE next cycle; WrEn drops the same edge. Abort and Arm in the same cycle: Abort wins.
- Arm while in PRE, ARMED or POST: ignored.
- Hit in the same cycle as the PRE→ARMED transition: ignored, because TrigEN is still 0.
- WrAddr wraps modulo 2^ADDR_W with no flag. Readout starts at TrigAddr - PRE_CNT (mod depth).

Optional Feature:
- Macro: TRIG_FORCE_EN.
- With the macro defined:
  - Adds input ForceTrig (1 bit).
  - In ARMED, Hit_eff = Hit | ForceTrig.
  - Adds output Forced, sticky and cleared on leaving DONE; it is set if the trigger came from ForceTrig while Hit was 0.
  - In PRE, ForceTrig is latched and honoured on the first ARMED cycle.
- Without the macro: no ForceTrig or Forced ports; only Hit triggers.

Decomposition:
- Shared package trig_pkg holds:
  - state encoding constants ST_IDLE=0, ST_PRE=1, ST_ARMED=2, ST_POST=3, ST_DONE=4 (3 bits);
  - the default ADDR_W;
  - PRE_CNT bounds.
- One sub-module: trig_align_dly, a parameterised WIDTH x DEPTH shift register used for the Din alignment.

Test Plan:
- ADDR_W=4, PRE_CNT=4, ResTri=all 1 from cycle 0, Arm at cycle 5:
  - Expect 4 PRE writes at addresses 0..3.
  - Trigger on the first ARMED cycle: TrigAddr=4.
  - 11 POST writes, addresses 5..15.
  - Done=1 with WrEn=0 afterwards.
- ResTri=8'hFE held 100 cycles in ARMED, then 8'hFF:
  - Triggered rises one cycle after the 8'hFF sample.
  - TrigAddr equals WrAddr at that cycle, including a wrapped value such as 3 after 0..15.
- Din=8'hA5 for one cycle with aligned ResTri=all 1: the word written at TrigAddr is 8'hA5, confirming ALIGN_DLY=2.
- RST pulsed in POST: next cycle all outputs are 0 and the state is IDLE; a subsequent Arm restarts from WrAddr=0.
- Abort and Arm together in ARMED → IDLE. Arm in POST → ignored, write count unchanged.
- With TRIG_FORCE_EN, ResTri=0 and ForceTrig pulsed in ARMED → Triggered=1, Forced=1. Without the macro, the ports are absent from the elaborated design.
